// File: rtl/ifc_mon_pkg.sv
// Shared types and constants for the ifc counter monitor.
// Imported by the interface, the stall detector and the top level.
package ifc_mon_pkg;

    localparam int VALUE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RST_HOLD,
        RUN,
        STALL
    } mon_state_e;

    function automatic bit params_ok(input int rst_cycles, input int stall_cycles, input int ext_w);
        return (rst_cycles >= 1) && (rst_cycles <= 255) &&
               (stall_cycles >= 2) && (stall_cycles <= 255) &&
               (ext_w > VALUE_W);
    endfunction

endpackage

// File: rtl/ifc_if.sv
// Link between the core-side monitor and the 4-bit counter it supervises.
// The core drives the counter reset; the counter returns its value.
interface ifc;
    import ifc_mon_pkg::*;

    logic               reset;
    logic [VALUE_W-1:0] value;

    modport core_mp (output reset, input value);
    modport cnt_mp  (input reset, output value);

endinterface

// File: rtl/ifc_stall_det.sv
// Counts consecutive equal samples of the counter value and pulses stall_hit
// on the sample that completes a run of STALL_CYCLES.
module ifc_stall_det
    import ifc_mon_pkg::*;
#(
    parameter int STALL_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [VALUE_W-1:0] value,
    input  logic [VALUE_W-1:0] prev,
    output logic               stall_hit
);

    logic [7:0] eq_cnt;
    logic       same;

    assign same      = en && (value == prev);
    assign stall_hit = same && (eq_cnt == 8'(STALL_CYCLES - 1));

    // Saturates at STALL_CYCLES so a long freeze yields a single pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_cnt <= '0;
        end else if (!same) begin
            eq_cnt <= '0;
        end else if (eq_cnt != 8'(STALL_CYCLES)) begin
            eq_cnt <= eq_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/ifc_counter_monitor.sv
// Core-side controller for the ifc counter: reset sequencing, wrap tracking
// into a wide count, stall detection and a valid/ready snapshot port.
module ifc_counter_monitor
    import ifc_mon_pkg::*;
#(
    parameter int RST_CYCLES   = 4,
    parameter int STALL_CYCLES = 8,
    parameter int EXT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    ifc.core_mp              c_data,
    output logic             snap_valid,
    input  logic             snap_ready,
    output logic [EXT_W-1:0] snap_count,
    output logic             snap_lost,
    output logic             stalled,
    output logic             busy
);

    localparam int HI_W = EXT_W - VALUE_W;

    if (!params_ok(RST_CYCLES, STALL_CYCLES, EXT_W)) begin : g_param_err
        $error("ifc_counter_monitor: parameter out of range");
    end

    mon_state_e         state, next_state;
    logic [7:0]         hold_cnt;
    logic [VALUE_W-1:0] prev;
    logic               prev_ok;
    logic [HI_W-1:0]    hi;
    logic [HI_W-1:0]    hi_inc;
    logic               reset_q;
    logic               eval;
    logic               wrap;
    logic               changed;
    logic               hold_done;
    logic               stall_hit;

    // No wrap/stall evaluation until prev holds a real sample from this run.
    assign eval      = prev_ok && ((state == RUN) || (state == STALL));
    assign wrap      = eval && (c_data.value < prev);
    assign changed   = eval && (c_data.value != prev);
    assign hold_done = (hold_cnt == 8'(RST_CYCLES - 1));
    assign hi_inc    = hi + 1'b1;
    assign c_data.reset = reset_q;

    ifc_stall_det #(
        .STALL_CYCLES(STALL_CYCLES)
    ) u_stall_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (eval),
        .value     (c_data.value),
        .prev      (prev),
        .stall_hit (stall_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (stop) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:     if (start)     next_state = RST_HOLD;
                RST_HOLD: if (hold_done) next_state = RUN;
                RUN:      if (stall_hit) next_state = STALL;
                STALL:    if (changed)   next_state = RUN;
                default:                 next_state = IDLE;
            endcase
        end
    end

    // reset_q and busy follow next_state so both outputs stay registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reset_q    <= 1'b1;
            busy       <= 1'b0;
            hold_cnt   <= '0;
            prev       <= '0;
            prev_ok    <= 1'b0;
            hi         <= '0;
            snap_valid <= 1'b0;
            snap_count <= '0;
            snap_lost  <= 1'b0;
            stalled    <= 1'b0;
        end else begin
            reset_q  <= (next_state == IDLE) || (next_state == RST_HOLD);
            busy     <= (next_state != IDLE);
            hold_cnt <= (state == RST_HOLD) ? hold_cnt + 8'd1 : '0;
            if (stop) begin
                snap_valid <= 1'b0;
                prev_ok    <= 1'b0;
            end else if (state == IDLE) begin
                if (start) begin
                    snap_lost  <= 1'b0;
                    stalled    <= 1'b0;
                    hi         <= '0;
                    snap_valid <= 1'b0;
                    snap_count <= '0;
                    prev_ok    <= 1'b0;
                end
            end else if ((state == RUN) || (state == STALL)) begin
                prev    <= c_data.value;
                prev_ok <= 1'b1;
                // A wrap may reuse the slot freed by a same-cycle transfer.
                if (wrap) begin
                    hi <= hi_inc;
                    if (!snap_valid || snap_ready) begin
                        snap_count <= {hi_inc, c_data.value};
                        snap_valid <= 1'b1;
                    end else begin
                        snap_lost <= 1'b1;
                    end
                end else if (snap_valid && snap_ready) begin
                    snap_valid <= 1'b0;
                end
                if (stall_hit) begin
                    stalled <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifc_counter_monitor.sv
// Directed bench for ifc_counter_monitor: a vector table for start-up and the
// first two wraps, then hand-written sequences for the multi-cycle corners.
module tb_ifc_counter_monitor;
    import ifc_mon_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        snap_ready = 1'b0;
    logic        snap_valid, snap_lost, stalled, busy;
    logic [15:0] snap_count;

    logic        start8 = 1'b0;
    logic        stop8 = 1'b0;
    logic        ready8 = 1'b1;
    logic        valid8, lost8, stalled8, busy8;
    logic [7:0]  count8;

    ifc bus();
    ifc bus8();

    ifc_counter_monitor #(.RST_CYCLES(4), .STALL_CYCLES(8), .EXT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .c_data(bus.core_mp),
        .snap_valid(snap_valid), .snap_ready(snap_ready), .snap_count(snap_count),
        .snap_lost(snap_lost), .stalled(stalled), .busy(busy)
    );

    ifc_counter_monitor #(.RST_CYCLES(1), .STALL_CYCLES(2), .EXT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .stop(stop8), .c_data(bus8.core_mp),
        .snap_valid(valid8), .snap_ready(ready8), .snap_count(count8),
        .snap_lost(lost8), .stalled(stalled8), .busy(busy8)
    );

    always #5 clk = ~clk;

    // ctl = {start, stop, snap_ready}; e_flags = {reset, busy, valid}; e_sticky = {lost, stalled}
    typedef struct {
        logic [2:0]  ctl;
        logic [3:0]  value;
        logic [2:0]  e_flags;
        logic [15:0] e_count;
        logic [1:0]  e_sticky;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic [2:0] ctl, input logic [3:0] value,
                                input logic [2:0] e_flags, input logic [15:0] e_count,
                                input logic [1:0] e_sticky);
        vec_t v;
        v.ctl      = ctl;
        v.value    = value;
        v.e_flags  = e_flags;
        v.e_count  = e_count;
        v.e_sticky = e_sticky;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] ctl, input logic [3:0] value);
        {start, stop, snap_ready} = ctl;
        bus.value = value;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [2:0] e_flags,
                               input logic [15:0] e_count, input logic [1:0] e_sticky);
        logic [20:0] act;
        logic [20:0] exp;
        act = {bus.reset, busy, snap_valid, snap_count, snap_lost, stalled};
        exp = {e_flags, e_count, e_sticky};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got reset/busy/valid=%b count=%h lost/stalled=%b, expected %b %h %b",
                     name, act[20:18], act[17:2], act[1:0], exp[20:18], exp[17:2], exp[1:0]);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        bus.value  = 4'd0;
        bus8.value = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_low", 3'b100, 16'h0000, 2'b00);
        rst_n = 1'b1;
        tick();
        checkOutput("reset_idle", 3'b100, 16'h0000, 2'b00);
        checkValue("reset_state", 32'(dut.state), 32'(IDLE));

        // Start-up, reset hold, first RUN cycle and two full laps with ready high.
        vecs.push_back(mk(3'b001, 4'd0, 3'b100, 16'h0000, 2'b00));
        vecs.push_back(mk(3'b101, 4'd0, 3'b110, 16'h0000, 2'b00));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(3'b001, 4'd0, 3'b110, 16'h0000, 2'b00));
        vecs.push_back(mk(3'b001, 4'd0, 3'b010, 16'h0000, 2'b00));
        vecs.push_back(mk(3'b001, 4'd0, 3'b010, 16'h0000, 2'b00));
        for (int v = 1; v < 16; v++) vecs.push_back(mk(3'b001, 4'(v), 3'b010, 16'h0000, 2'b00));
        vecs.push_back(mk(3'b001, 4'd0, 3'b011, 16'h0010, 2'b00));
        vecs.push_back(mk(3'b001, 4'd1, 3'b010, 16'h0010, 2'b00));
        for (int v = 2; v < 16; v++) vecs.push_back(mk(3'b001, 4'(v), 3'b010, 16'h0010, 2'b00));
        vecs.push_back(mk(3'b001, 4'd0, 3'b011, 16'h0020, 2'b00));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].ctl, vecs[i].value);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_flags, vecs[i].e_count, vecs[i].e_sticky);
        end

        // Ready low across two more wraps: old snapshot held, lost flagged.
        applyStimulus(3'b000, 4'd1);
        checkOutput("hold_pending", 3'b011, 16'h0020, 2'b00);
        for (int v = 2; v < 16; v++) applyStimulus(3'b000, 4'(v));
        applyStimulus(3'b000, 4'd0);
        checkOutput("lost_wrap3", 3'b011, 16'h0020, 2'b10);
        for (int v = 1; v < 16; v++) applyStimulus(3'b000, 4'(v));
        applyStimulus(3'b000, 4'd0);
        checkOutput("lost_wrap4", 3'b011, 16'h0020, 2'b10);
        applyStimulus(3'b001, 4'd1);
        checkOutput("late_transfer", 3'b010, 16'h0020, 2'b10);

        // Freeze at 7: the eighth equal sample declares the stall.
        for (int v = 2; v < 8; v++) applyStimulus(3'b001, 4'(v));
        for (int i = 0; i < 7; i++) applyStimulus(3'b001, 4'd7);
        checkOutput("stall_pre", 3'b010, 16'h0020, 2'b10);
        applyStimulus(3'b001, 4'd7);
        checkOutput("stall_hit", 3'b010, 16'h0020, 2'b11);
        checkValue("stall_state", 32'(dut.state), 32'(STALL));
        applyStimulus(3'b001, 4'd8);
        checkOutput("stall_exit", 3'b010, 16'h0020, 2'b11);
        checkValue("run_state", 32'(dut.state), 32'(RUN));

        // Stall at 15, then leave it with a wrap on the same cycle.
        for (int v = 9; v < 16; v++) applyStimulus(3'b001, 4'(v));
        for (int i = 0; i < 8; i++) applyStimulus(3'b001, 4'd15);
        checkValue("stall2_state", 32'(dut.state), 32'(STALL));
        applyStimulus(3'b001, 4'd0);
        checkOutput("stall_wrap", 3'b011, 16'h0050, 2'b11);
        checkValue("stall_wrap_state", 32'(dut.state), 32'(RUN));
        applyStimulus(3'b000, 4'd1);
        checkOutput("pending_again", 3'b011, 16'h0050, 2'b11);

        // start and stop together: stop wins, sticky flags survive until next start.
        applyStimulus(3'b110, 4'd2);
        checkOutput("start_stop", 3'b100, 16'h0050, 2'b11);
        checkValue("stop_state", 32'(dut.state), 32'(IDLE));
        applyStimulus(3'b000, 4'd0);
        checkOutput("idle_sticky", 3'b100, 16'h0050, 2'b11);
        applyStimulus(3'b100, 4'd0);
        checkOutput("restart_clears", 3'b110, 16'h0000, 2'b00);

        // Second run, then async reset with a snapshot pending.
        for (int i = 0; i < 3; i++) applyStimulus(3'b000, 4'd0);
        applyStimulus(3'b000, 4'd0);
        checkOutput("rerun_release", 3'b010, 16'h0000, 2'b00);
        applyStimulus(3'b000, 4'd0);
        for (int v = 1; v < 16; v++) applyStimulus(3'b000, 4'(v));
        applyStimulus(3'b000, 4'd0);
        checkOutput("rerun_wrap", 3'b011, 16'h0010, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 3'b100, 16'h0000, 2'b00);
        checkValue("async_state", 32'(dut.state), 32'(IDLE));
        tick();
        rst_n = 1'b1;
        tick();

        // EXT_W=8 instance: hi is 4 bits and must roll 15 -> 0 cleanly.
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        checkValue("w8_hold", 32'({bus8.reset, busy8}), 32'h3);
        tick();
        checkValue("w8_release", 32'({bus8.reset, busy8}), 32'h1);
        tick();
        for (int lap = 1; lap <= 17; lap++) begin
            for (int v = 1; v < 16; v++) begin
                bus8.value = 4'(v);
                tick();
            end
            bus8.value = 4'd0;
            tick();
            if (lap >= 14) begin
                checkValue($sformatf("w8_lap%0d", lap), 32'({valid8, count8}), 32'({1'b1, 8'(lap * 16)}));
            end
        end
        checkValue("w8_sticky", 32'({lost8, stalled8}), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
